// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one unified memory port, one transaction outstanding.
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    output logic [3:0]    m_be,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [31:0]   m_rdata,
    output logic          busy,
    output logic          spurious
);

    localparam int CW = $clog2(MAX_D_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_D_BURST);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            h_we;
    logic [AW-1:0]   h_addr;
    logic [31:0]     h_wdata;
    logic [3:0]      h_be;
    logic            win_i;
    logic            win_d;
    logic            in_wait;

    // Data wins contention unless fetch has already waited out a full data burst.
    assign win_d   = d_req && (!i_req || (cnt != CNT_MAX));
    assign win_i   = i_req && !win_d;
    assign in_wait = (state == WAIT_I) || (state == WAIT_D);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (win_d) begin
                    state_nx = m_gnt ? WAIT_D : REQ_D;
                end else if (win_i) begin
                    state_nx = m_gnt ? WAIT_I : REQ_I;
                end
            end
            REQ_I:   if (m_gnt) state_nx = WAIT_I;
            REQ_D:   if (m_gnt) state_nx = WAIT_D;
            WAIT_I:  if (m_rvalid) state_nx = IDLE;
            WAIT_D:  if (m_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_be     = '0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (win_d) begin
                        m_req   = 1'b1;
                        m_we    = d_we;
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                        m_be    = d_be;
                        d_gnt   = m_gnt;
                    end else if (win_i) begin
                        m_req  = 1'b1;
                        m_addr = i_addr;
                        m_be   = 4'hF;
                        i_gnt  = m_gnt;
                    end
                end
                REQ_I, REQ_D: begin
                    m_req   = 1'b1;
                    m_we    = h_we;
                    m_addr  = h_addr;
                    m_wdata = h_wdata;
                    m_be    = h_be;
                    i_gnt   = (state == REQ_I) && m_gnt;
                    d_gnt   = (state == REQ_D) && m_gnt;
                end
                WAIT_I: begin
                    i_rvalid = m_rvalid;
                    i_rdata  = m_rvalid ? m_rdata : '0;
                end
                WAIT_D: begin
                    d_rvalid = m_rvalid;
                    d_rdata  = m_rvalid ? m_rdata : '0;
                end
                default: ;
            endcase
        end
    end

    // Hold registers freeze the winner's request so REQ_x ignores later input changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_we    <= 1'b0;
            h_addr  <= '0;
            h_wdata <= '0;
            h_be    <= '0;
        end else if (state == IDLE) begin
            if (win_d) begin
                h_we    <= d_we;
                h_addr  <= d_addr;
                h_wdata <= d_wdata;
                h_be    <= d_be;
            end else if (win_i) begin
                h_we    <= 1'b0;
                h_addr  <= i_addr;
                h_wdata <= '0;
                h_be    <= 4'hF;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (d_gnt) begin
            if (!i_req) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end else if (i_gnt) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spurious <= 1'b0;
        end else if (m_rvalid && !in_wait) begin
            spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter grants, responses, starvation bound and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        busy;
    logic        spurious;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;

    rsp_t rq[$];
    logic gq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter #(.AW(32), .MAX_D_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .spurious(spurious)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        i_addr = 32'h4; d_addr = 32'h8;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, busy, spurious} !== 7'b0 ||
                i_rdata !== 32'h0 || d_rdata !== 32'h0 || m_addr !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_outputs c%0d: m_req=%b i_gnt=%b d_gnt=%b i_rv=%b d_rv=%b busy=%b spur=%b i_rdata=%h d_rdata=%h m_addr=%h, required all 0",
                         c, m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, busy, spurious, i_rdata, d_rdata, m_addr);
            end
            step();
        end
        i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; i_addr = '0; d_addr = '0;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || dut.cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_release: busy=%b cnt=%0d, required 0/0", busy, dut.cnt);
        end
        step();
    endtask

    task automatic test_single_fetch();
        rsp_t e;
        i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            n_bad++; $display("FAIL fetch_gnt: i_gnt=%b d_gnt=%b, required 1/0", i_gnt, d_gnt);
        end
        n_cmp++;
        if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0 || m_be !== 4'hF) begin
            n_bad++; $display("FAIL fetch_mreq: m_req=%b m_addr=%h m_we=%b m_be=%h, required 1/100/0/f", m_req, m_addr, m_we, m_be);
        end
        rq.push_back('{1'b0, 32'hDEAD_BEEF});
        step();
        i_req = 1'b0; i_addr = '0; m_gnt = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || m_req !== 1'b0 || m_addr !== 32'h0 || i_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL fetch_wait: busy=%b m_req=%b m_addr=%h i_rv=%b, required 1/0/0/0", busy, m_req, m_addr, i_rvalid);
        end
        step();
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        e = rq.pop_front();
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_rdata !== e.data || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL fetch_resp: i_rv=%b i_rdata=%h d_rv=%b d_rdata=%h, required 1/%h/0/0", i_rvalid, i_rdata, d_rvalid, d_rdata, e.data);
        end
        step();
        m_rvalid = 1'b0; m_rdata = '0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL fetch_idle: busy=%b, required 0", busy);
        end
        step();
    endtask

    task automatic test_contention();
        rsp_t e;
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; m_gnt = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || m_addr !== 32'h40) begin
            n_bad++; $display("FAIL contention_first: d_gnt=%b i_gnt=%b m_addr=%h, required 1/0/40", d_gnt, i_gnt, m_addr);
        end
        rq.push_back('{1'b1, 32'h1111_2222});
        step();
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b0 || m_req !== 1'b0) begin
            n_bad++; $display("FAIL contention_wait: i_gnt=%b m_req=%b, required 0/0", i_gnt, m_req);
        end
        step();
        m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
        @(negedge clk);
        e = rq.pop_front();
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== e.data || i_rvalid !== 1'b0 || i_gnt !== 1'b0) begin
            n_bad++; $display("FAIL contention_dresp: d_rv=%b d_rdata=%h i_rv=%b i_gnt=%b, required 1/%h/0/0", d_rvalid, d_rdata, i_rvalid, i_gnt, e.data);
        end
        step();
        m_rvalid = 1'b0; m_rdata = '0;
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1 || m_addr !== 32'h200 || m_we !== 1'b0) begin
            n_bad++; $display("FAIL contention_igrant: i_gnt=%b m_addr=%h m_we=%b, required 1/200/0", i_gnt, m_addr, m_we);
        end
        rq.push_back('{1'b0, 32'hCAFE_0001});
        step();
        i_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
        @(negedge clk);
        e = rq.pop_front();
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_rdata !== e.data || d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL contention_iresp: i_rv=%b i_rdata=%h d_rv=%b, required 1/%h/0", i_rvalid, i_rdata, d_rvalid, e.data);
        end
        step();
        m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic test_starvation();
        logic        pending = 1'b0;
        logic [31:0] pdata = '0;
        logic        done = 1'b0;
        logic        stop = 1'b0;
        logic        eg;
        int          grants = 0;
        rsp_t        e;
        gq.push_back(1'b1); gq.push_back(1'b1); gq.push_back(1'b1); gq.push_back(1'b1); gq.push_back(1'b0);
        i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; m_gnt = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            m_rvalid = pending; m_rdata = pending ? pdata : 32'h0;
            pending = 1'b0;
            @(negedge clk);
            if (d_gnt || i_gnt) begin
                grants++;
                eg = (gq.size() != 0) ? gq.pop_front() : 1'bx;
                n_cmp++;
                if ((d_gnt && i_gnt) || d_gnt !== eg) begin
                    n_bad++; $display("FAIL starve_order g%0d: d_gnt=%b i_gnt=%b, required d_gnt=%b", grants, d_gnt, i_gnt, eg);
                end
                pdata = $urandom; pending = 1'b1;
                rq.push_back('{d_gnt, pdata});
                if (i_gnt) stop = 1'b1;
            end
            if (i_rvalid || d_rvalid) begin
                n_cmp++;
                if (rq.size() == 0) begin
                    n_bad++; $display("FAIL starve_resp: unexpected rvalid i=%b d=%b, required none", i_rvalid, d_rvalid);
                end else begin
                    e = rq.pop_front();
                    if (d_rvalid !== e.is_d || i_rvalid !== !e.is_d ||
                        (e.is_d ? d_rdata : i_rdata) !== e.data || (e.is_d ? i_rdata : d_rdata) !== 32'h0) begin
                        n_bad++; $display("FAIL starve_resp: i_rv=%b d_rv=%b i_rdata=%h d_rdata=%h, required owner_d=%b data=%h",
                                          i_rvalid, d_rvalid, i_rdata, d_rdata, e.is_d, e.data);
                    end
                    if (!e.is_d) done = 1'b1;
                end
            end
            step();
            if (stop) begin
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        m_rvalid = 1'b0; m_rdata = '0; m_gnt = 1'b0;
        n_cmp++;
        if (!done || grants != 5 || gq.size() != 0) begin
            n_bad++; $display("FAIL starve_bound: done=%b grants=%0d left=%0d, required 1/5/0", done, grants, gq.size());
        end
        n_cmp++;
        if (dut.cnt !== 3'd0) begin
            n_bad++; $display("FAIL starve_cnt: cnt=%0d, required 0", dut.cnt);
        end
        gq.delete(); rq.delete();
    endtask

    task automatic test_backpressure();
        rsp_t e;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55AA; d_be = 4'b0011; m_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_gnt = (c == 3);
            @(negedge clk);
            n_cmp++;
            if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h20 || m_wdata !== 32'h55AA ||
                m_be !== 4'b0011 || d_gnt !== (c == 3) || i_gnt !== 1'b0) begin
                n_bad++; $display("FAIL backpressure c%0d: m_req=%b m_we=%b m_addr=%h m_wdata=%h m_be=%b d_gnt=%b, required 1/1/20/55aa/0011/%b",
                                  c, m_req, m_we, m_addr, m_wdata, m_be, d_gnt, (c == 3));
            end
            step();
            d_addr = 32'h999 + c; d_wdata = 32'h1234 + c; d_be = 4'b1100;
        end
        rq.push_back('{1'b1, 32'h0000_ABCD});
        d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_ABCD;
        @(negedge clk);
        e = rq.pop_front();
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== e.data || i_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL backpressure_ack: d_rv=%b d_rdata=%h i_rv=%b, required 1/%h/0", d_rvalid, d_rdata, i_rvalid, e.data);
        end
        step();
        m_rvalid = 1'b0; m_rdata = '0; d_we = 1'b0; d_be = 4'hF;
    endtask

    task automatic test_spurious();
        m_rvalid = 1'b1; m_rdata = 32'h1234; m_gnt = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0 ||
            i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_req !== 1'b0) begin
            n_bad++; $display("FAIL spurious_drop: i_rv=%b d_rv=%b i_rdata=%h d_rdata=%h gnt=%b%b m_req=%b, required all 0",
                              i_rvalid, d_rvalid, i_rdata, d_rdata, i_gnt, d_gnt, m_req);
        end
        step();
        m_rvalid = 1'b0; m_rdata = '0; m_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (spurious !== 1'b1 || busy !== 1'b0) begin
                n_bad++; $display("FAIL spurious_sticky c%0d: spurious=%b busy=%b, required 1/0", c, spurious, busy);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60; m_gnt = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_bad++; $display("FAIL resetmid_gnt: d_gnt=%b, required 1", d_gnt);
        end
        step();
        d_req = 1'b0; m_gnt = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL resetmid_wait: busy=%b, required 1", busy);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || spurious !== 1'b0) begin
            n_bad++; $display("FAIL resetmid_async: busy=%b spurious=%b, required 0/0", busy, spurious);
        end
        step();
        reset = 1'b1;
        step();
        m_rvalid = 1'b1; m_rdata = 32'h0000_0BAD;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || i_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL resetmid_late: d_rv=%b d_rdata=%h i_rv=%b, required 0/0/0", d_rvalid, d_rdata, i_rvalid);
        end
        step();
        m_rvalid = 1'b0; m_rdata = '0;
        @(negedge clk);
        n_cmp++;
        if (spurious !== 1'b1) begin
            n_bad++; $display("FAIL resetmid_spurious: spurious=%b, required 1", spurious);
        end
        step();
    endtask

    initial begin
        reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; d_be = 4'hF; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        #1;
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t, required completion before 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). It sits between `fetch`/`memory` and the external memory model. It serialises requests with one transaction outstanding, gives data priority over fetch with a bounded-starvation guarantee, and routes each response back to its owner.

## Interface
- `AW`, default 32: address width.
- `MAX_D_BURST`, default 4: maximum consecutive data grants while a fetch request waits; must be ≥1.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset; asserted when 0.
- `i_req` in 1: fetch read request; held high until `i_gnt`.
- `i_addr` in AW: fetch address.
- `i_gnt` out 1: fetch request accepted by memory this cycle.
- `i_rvalid` out 1: fetch read data valid.
- `i_rdata` out 32: fetch read data; 0 when `i_rvalid`=0.
- `d_req` in 1: data request; held high until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in AW, `d_wdata` in 32, `d_be` in 4: data address, store data, byte enables.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: load data or store acknowledge valid.
- `d_rdata` out 32: load data; 0 when `d_rvalid`=0.
- `m_req` out 1, `m_we` out 1, `m_addr` out AW, `m_wdata` out 32, `m_be` out 4: request to memory.
- `m_gnt` in 1: memory accepts the request presented this cycle.
- `m_rvalid` in 1, `m_rdata` in 32: memory response.
- `busy` out 1: state ≠ IDLE.
- `spurious` out 1: sticky; set when `m_rvalid`=1 outside a WAIT state.

## Operation
- States: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D.
- IDLE winner: none if neither requests. Otherwise D if only `d_req`, or I if only `i_req`. If both request, I wins when `cnt`==MAX_D_BURST, else D.
- IDLE with a winner:
  - Drive `m_*` combinationally from the winner's inputs and capture them into hold registers.
  - Fetch requests drive `m_we`=0 and `m_be`=4'hF.
  - If `m_gnt`=1, assert the winner's gnt and go to WAIT_x.
  - Otherwise go to REQ_x.
- REQ_x:
  - `m_req`=1 with `m_*` from the hold registers; the selection never changes.
  - Requester inputs are ignored in this state.
  - On `m_gnt`, pulse the owner's gnt and go to WAIT_x.
- WAIT_x:
  - `m_req`=0.
  - On `m_rvalid`, assert the owner's rvalid with rdata=`m_rdata` and return to IDLE.
  - The other requester's rvalid stays 0.
- Starvation counter `cnt`, width clog2(MAX_D_BURST+1):
  - On a D grant with `i_req`=1 that cycle: increment, saturating at MAX_D_BURST.
  - On a D grant with `i_req`=0: clear to 0.
  - On an I grant: clear to 0.
- Outside IDLE, `m_*` data fields are driven from the hold registers. When `m_req`=0, all `m_*` fields are 0.
- A `m_rvalid` pulse in IDLE or REQ_x is dropped and sets `spurious`.
- `m_gnt` while `m_req`=0 is ignored.

## Timing
- Reset (async assert, sync-safe release):
  - state IDLE, `cnt`=0, `spurious`=0, hold registers 0.
  - All outputs are 0: `m_req`, `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, rdata, `busy`.
- Reset during REQ_x or WAIT_x abandons the transaction. A later `m_rvalid` sets `spurious`.
- Grant latency:
  - 0 cycles when IDLE, uncontended and `m_gnt`=1: gnt is asserted in the same cycle as req.
  - Otherwise the grant arrives in the cycle `m_gnt` rises.
- Response is visible to the owner in the same cycle as `m_rvalid` (combinational pass-through). The earliest response is the cycle after the grant.
- There is always one IDLE cycle after a response before the next grant; maximum throughput is one transaction per 2 cycles.
- gnt and rvalid are single-cycle pulses.

## Test plan
- Reset and single fetch:
  - Stimulus: hold `reset`=0 for 3 cycles; then `i_req`=1, `i_addr`=0x100, `m_gnt`=1, and `m_rvalid` 2 cycles later with 0xDEADBEEF.
  - Required: all outputs 0 during reset; `i_gnt` in the request cycle; `m_addr`=0x100, `m_we`=0; `i_rdata`=0xDEADBEEF with `i_rvalid`, `d_rvalid`=0.
- Contention:
  - Stimulus: `i_req` and `d_req` both asserted from IDLE, `cnt`=0.
  - Required: `d_gnt` first; `i_gnt` only after the D response plus the IDLE cycle.
- Starvation bound:
  - Stimulus: `i_req` held high while `d_req` is held high continuously, MAX_D_BURST=4.
  - Required: exactly 4 D grants, then 1 I grant; `cnt` returns to 0.
- Backpressure:
  - Stimulus: `d_req` store with addr 0x20, wdata 0x55AA, `d_be`=4'b0011, `m_gnt`=0 for 3 cycles; `d_addr` changes after the first cycle.
  - Required: `m_addr`=0x20, `m_wdata`=0x55AA, `m_be`=4'b0011 held stable; `d_gnt` pulses on the `m_gnt` cycle.
- Spurious response:
  - Stimulus: `m_rvalid` in IDLE.
  - Required: no rvalid to either port; `spurious`=1 until reset.
- Reset mid-transaction:
  - Stimulus: assert `reset` in WAIT_D.
  - Required: state IDLE immediately, `busy`=0; a later `m_rvalid` sets `spurious` and does not assert `d_rvalid`.
